// File: rtl/terc4_data_island_encoder.sv
// TERC4 data island encoder for an HDMI TMDS link.
// Emits one data island per accepted start: preamble, leading guard band,
// 32*NUM_PACKETS TERC4 data symbols and a trailing guard band.
// All three TMDS characters are registered.
// data_rd is decoded from the state register and has no path from any input.
// Optional macro: TERC4_START_QUEUE_EN.
//   When defined, a start that arrives while an island is in flight is held in
//   a one-deep pending flag. The queued island launches after 4 IDLE control
//   cycles.
//   When undefined, such a start is dropped.
// Handshake: data_rd is high in exactly the cycles whose hdr_bit/ch1_data/
// ch2_data are sampled at the closing clock edge. The source must present a
// fresh nibble set in every data_rd cycle; there is no back-pressure.
module terc4_data_island_encoder #(
    parameter int NUM_PACKETS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hdr_bit,
    input  logic [3:0] ch1_data,
    input  logic [3:0] ch2_data,
    output logic       data_rd,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int DATA_LEN = 32 * NUM_PACKETS;
    localparam int CW       = $clog2(DATA_LEN);

    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_LEN - 1);
    localparam logic [CW-1:0] LAST_PRE  = CW'(7);
    localparam logic [CW-1:0] LAST_GRD  = CW'(1);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;
    localparam logic [9:0] GUARD   = 10'b0100110011;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PREAMBLE    = 3'd1,
        LEAD_GUARD  = 3'd2,
        DATA        = 3'd3,
        TRAIL_GUARD = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    tmds_ch0_q, tmds_ch0_d;
    logic [9:0]    tmds_ch1_q, tmds_ch1_d;
    logic [9:0]    tmds_ch2_q, tmds_ch2_d;
    logic          first_n;

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] r;
        unique case (c)
            2'b00:   r = CTRL_00;
            2'b01:   r = CTRL_01;
            2'b10:   r = CTRL_10;
            default: r = CTRL_11;
        endcase
        return r;
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] d);
        logic [9:0] r;
        unique case (d)
            4'b0000: r = 10'b1010011100;
            4'b0001: r = 10'b1001100011;
            4'b0010: r = 10'b1011100100;
            4'b0011: r = 10'b1011100010;
            4'b0100: r = 10'b0101110001;
            4'b0101: r = 10'b0100011110;
            4'b0110: r = 10'b0110001110;
            4'b0111: r = 10'b0100111100;
            4'b1000: r = 10'b1011001100;
            4'b1001: r = 10'b0100111001;
            4'b1010: r = 10'b0110011100;
            4'b1011: r = 10'b1011000110;
            4'b1100: r = 10'b1010001110;
            4'b1101: r = 10'b1001110001;
            4'b1110: r = 10'b0101100011;
            default: r = 10'b1011000011;
        endcase
        return r;
    endfunction

    // The low five counter bits are the symbol index within a packet.
    // They wrap 31->0 at each packet boundary.
    assign first_n = |cnt_q[4:0];

`ifdef TERC4_START_QUEUE_EN
    logic pend_q, pend_d;

    // Pending flag: armed by a start seen mid-island, cleared on launch.
    always_comb begin
        pend_d = pend_q;
        if (state_q != IDLE) begin
            if (start) pend_d = 1'b1;
        end else if (pend_q && cnt_q == CW'(3)) begin
            pend_d = 1'b0;
        end
    end

    // Pending flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= 1'b0;
        else     pend_q <= pend_d;
    end
`endif

    // Next-state and phase counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
`ifdef TERC4_START_QUEUE_EN
                if (pend_q) begin
                    if (cnt_q == CW'(3)) begin
                        state_d = PREAMBLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (start) begin
                    state_d = PREAMBLE;
                end
`else
                if (start) state_d = PREAMBLE;
`endif
            end
            PREAMBLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_PRE) begin
                    state_d = LEAD_GUARD;
                    cnt_d   = '0;
                end
            end
            LEAD_GUARD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_GRD) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_DATA) begin
                    state_d = TRAIL_GUARD;
                    cnt_d   = '0;
                end
            end
            TRAIL_GUARD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_GRD) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Character selection for the cycle being closed; it registers at the next edge.
    always_comb begin
        tmds_ch0_d = ctrl_code({vsync, hsync});
        tmds_ch1_d = CTRL_00;
        tmds_ch2_d = CTRL_00;
        unique case (state_q)
            PREAMBLE: begin
                tmds_ch1_d = CTRL_01;
                tmds_ch2_d = CTRL_01;
            end
            LEAD_GUARD, TRAIL_GUARD: begin
                tmds_ch0_d = terc4({2'b11, vsync, hsync});
                tmds_ch1_d = GUARD;
                tmds_ch2_d = GUARD;
            end
            DATA: begin
                tmds_ch0_d = terc4({first_n, hdr_bit, vsync, hsync});
                tmds_ch1_d = terc4(ch1_data);
                tmds_ch2_d = terc4(ch2_data);
            end
            default: begin
            end
        endcase
    end

    // State, counter and output character registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmds_ch0_q <= CTRL_00;
            tmds_ch1_q <= CTRL_00;
            tmds_ch2_q <= CTRL_00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmds_ch0_q <= tmds_ch0_d;
            tmds_ch1_q <= tmds_ch1_d;
            tmds_ch2_q <= tmds_ch2_d;
        end
    end

    assign data_rd   = (state_q == DATA);
    assign busy      = (state_q != IDLE);
    assign tmds_ch0  = tmds_ch0_q;
    assign tmds_ch1  = tmds_ch1_q;
    assign tmds_ch2  = tmds_ch2_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_terc4_data_island_encoder.sv
// Directed testbench for terc4_data_island_encoder.
// One instance is built with NUM_PACKETS=1 and one with NUM_PACKETS=2.
// The sel signal chooses which instance is stimulated and observed.
module tb_terc4_data_island_encoder;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  localparam logic [9:0] GUARD   = 10'b0100110011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_req;
  logic       sel;
  logic       hsync, vsync, hdr_bit;
  logic [3:0] ch1_data, ch2_data;

  logic       a_start, b_start;
  logic       a_rd, b_rd, a_busy, b_busy;
  logic [9:0] a_ch0, a_ch1, a_ch2, b_ch0, b_ch1, b_ch2;
  logic [2:0] a_st, b_st;

  assign a_start = start_req & ~sel;
  assign b_start = start_req & sel;

  terc4_data_island_encoder #(.NUM_PACKETS(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .hsync(hsync), .vsync(vsync),
    .hdr_bit(hdr_bit), .ch1_data(ch1_data), .ch2_data(ch2_data),
    .data_rd(a_rd), .tmds_ch0(a_ch0), .tmds_ch1(a_ch1), .tmds_ch2(a_ch2),
    .busy(a_busy), .dbg_state(a_st)
  );

  terc4_data_island_encoder #(.NUM_PACKETS(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .hsync(hsync), .vsync(vsync),
    .hdr_bit(hdr_bit), .ch1_data(ch1_data), .ch2_data(ch2_data),
    .data_rd(b_rd), .tmds_ch0(b_ch0), .tmds_ch1(b_ch1), .tmds_ch2(b_ch2),
    .busy(b_busy), .dbg_state(b_st)
  );

  logic       o_rd, o_busy;
  logic [9:0] o_ch0, o_ch1, o_ch2;
  assign o_rd   = sel ? b_rd   : a_rd;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_ch0  = sel ? b_ch0  : a_ch0;
  assign o_ch1  = sel ? b_ch1  : a_ch1;
  assign o_ch2  = sel ? b_ch2  : a_ch2;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference tables ----------------
  function automatic logic [9:0] ref_terc4(input logic [3:0] d);
    logic [9:0] t [16];
    t[0]  = 10'b1010011100; t[1]  = 10'b1001100011;
    t[2]  = 10'b1011100100; t[3]  = 10'b1011100010;
    t[4]  = 10'b0101110001; t[5]  = 10'b0100011110;
    t[6]  = 10'b0110001110; t[7]  = 10'b0100111100;
    t[8]  = 10'b1011001100; t[9]  = 10'b0100111001;
    t[10] = 10'b0110011100; t[11] = 10'b1011000110;
    t[12] = 10'b1010001110; t[13] = 10'b1001110001;
    t[14] = 10'b0101100011; t[15] = 10'b1011000011;
    return t[d];
  endfunction

  function automatic logic [9:0] ref_ctrl(input logic v, input logic h);
    logic [9:0] r;
    case ({v, h})
      2'b00:   r = 10'b1101010100;
      2'b01:   r = 10'b0010101011;
      2'b10:   r = 10'b0101010100;
      default: r = 10'b1010101011;
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_start();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
  endtask

  task automatic check_idle_chars(input string tag);
    check({tag, "_ch0"}, o_ch0, ref_ctrl(vsync, hsync));
    check({tag, "_ch1"}, o_ch1, CTRL_00);
    check({tag, "_ch2"}, o_ch2, CTRL_00);
  endtask

  // Called 1 time unit after the start-accept edge E0.
  // Walks the island through the second trailing-guard output and returns
  // 1 time unit after that edge.
  task automatic island_body(input int np, input bit special, input bit mid_start);
    int d_len;
    int busy_cnt;
    int rd_cnt;
    int first_cnt;
    int idx;
    logic       exp_hdr;
    logic [9:0] g0;
    logic [9:0] e0, e1, e2;
    d_len = 32 * np;
    busy_cnt = 0;
    rd_cnt = 0;
    first_cnt = 0;
    g0 = ref_terc4({2'b11, vsync, hsync});
    exp_hdr = 1'b0;
    for (int k = 0; k <= 12 + d_len; k++) begin
      if (k >= 1 && k <= 8) begin
        check("pre_ch0", o_ch0, ref_ctrl(vsync, hsync));
        check("pre_ch1", o_ch1, CTRL_01);
        check("pre_ch2", o_ch2, CTRL_01);
      end else if (k == 9 || k == 10 || k == 11 + d_len || k == 12 + d_len) begin
        check("grd_ch0", o_ch0, g0);
        check("grd_ch1", o_ch1, GUARD);
        check("grd_ch2", o_ch2, GUARD);
      end else if (k >= 11) begin
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        check("dat_ch0", o_ch0, e0);
        check("dat_ch1", o_ch1, e1);
        check("dat_ch2", o_ch2, e2);
        if (o_ch0 === ref_terc4({1'b0, exp_hdr, vsync, hsync})) first_cnt++;
        if (special && k == 11) begin
          check("r030_ch1", o_ch1, 10'b0100011110);
          check("r030_ch2", o_ch2, 10'b1011000011);
          check("r030_ch0", o_ch0, 10'b0100011110);
        end
      end
      if (o_busy === 1'b1) busy_cnt++;
      check("data_rd", o_rd, (k >= 10 && k < 10 + d_len));
      if (o_rd === 1'b1) rd_cnt++;
      if (k >= 10 && k < 10 + d_len) begin
        idx = k - 10;
        if (special && idx == 0) begin
          ch1_data = 4'b0101;
          ch2_data = 4'b1111;
          hdr_bit  = 1'b1;
        end else begin
          ch1_data = 4'((idx * 3) % 16);
          ch2_data = 4'((idx * 7 + 1) % 16);
          hdr_bit  = 1'((idx >> 2) & 1);
        end
        exp_hdr = hdr_bit;
        exp_q.push_back(ref_terc4({((idx % 32) != 0), hdr_bit, vsync, hsync}));
        exp_q.push_back(ref_terc4(ch1_data));
        exp_q.push_back(ref_terc4(ch2_data));
      end
      start_req = mid_start && (k == 15);
      if (k < 12 + d_len) tick();
    end
    start_req = 1'b0;
    check("busy_cycles", busy_cnt, 8 + 2 + d_len + 2);
    check("rd_cycles", rd_cnt, d_len);
    check("first_n_zero_syms", first_cnt, np);
    check("busy_end", o_busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start_req = 1'b0; sel = 1'b0;
    hsync = 1'b1; vsync = 1'b1; hdr_bit = 1'b0;
    ch1_data = 4'h0; ch2_data = 4'h0;

    // Reset held with both sync levels high.
    repeat (3) tick();
    check("rst_ch0", a_ch0, CTRL_00);
    check("rst_ch1", a_ch1, CTRL_00);
    check("rst_ch2", a_ch2, CTRL_00);
    check("rst_busy", a_busy, 1'b0);
    check("rst_rd", a_rd, 1'b0);
    check("rst_b_ch0", b_ch0, CTRL_00);
    rst = 1'b0;
    tick();
    check("post_rst_ch0", a_ch0, CTRL_11);
    check("post_rst_ch1", a_ch1, CTRL_00);

    // Basic island, NUM_PACKETS=1, syncs low.
    hsync = 1'b0; vsync = 1'b0;
    tick();
    check_idle_chars("idle0");
    accept_start();
    island_body(1, 1'b0, 1'b0);
    tick();
    check_idle_chars("trail_exit");

    // First data symbol carries a known header/nibble pattern with hsync high.
    hsync = 1'b1; vsync = 1'b0;
    repeat (2) tick();
    accept_start();
    island_body(1, 1'b1, 1'b0);
    tick();
    check_idle_chars("trail_exit2");

    // Two packets per island on the second instance.
    sel = 1'b1;
    hsync = 1'b0; vsync = 1'b1;
    repeat (2) tick();
    accept_start();
    island_body(2, 1'b0, 1'b0);
    tick();
    check_idle_chars("trail_exit_b");
    sel = 1'b0;

    // Reset asserted on data cycle 10 aborts the island.
    hsync = 1'b0; vsync = 1'b0;
    repeat (2) tick();
    accept_start();
    repeat (20) tick();
    check("abort_rd_before", a_rd, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_ch0", a_ch0, CTRL_00);
    check("abort_ch1", a_ch1, CTRL_00);
    check("abort_ch2", a_ch2, CTRL_00);
    check("abort_rd", a_rd, 1'b0);
    check("abort_busy", a_busy, 1'b0);
    tick();
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      check("abort_idle_rd", a_rd, 1'b0);
      check("abort_idle_busy", a_busy, 1'b0);
      check_idle_chars("abort_idle");
    end
    accept_start();
    island_body(1, 1'b0, 1'b0);

    // Start pulsed during DATA.
    repeat (2) tick();
    accept_start();
    island_body(1, 1'b0, 1'b1);
`ifdef TERC4_START_QUEUE_EN
    for (int j = 1; j <= 4; j++) begin
      tick();
      check_idle_chars("queue_gap");
      check("queue_busy", a_busy, (j == 4));
    end
    island_body(1, 1'b0, 1'b0);
    tick();
    check_idle_chars("queue_exit");
`else
    for (int j = 0; j < 8; j++) begin
      tick();
      check_idle_chars("drop_idle");
      check("drop_busy", a_busy, 1'b0);
      check("drop_rd", a_rd, 1'b0);
    end
`endif

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
